xmul_arb: RTL and testbench

- Round-robin arbiter and sequencer sharing one 3-stage pipelined signed multiplier (xmul_pipe) among N_REQ requesters.
- Accepts one operand pair per cycle via valid/ready and drives the multiplier operands.
- Tracks requester tags alongside the multiplier latency and steers each product back to its requester.
- Generates the multiplier's synchronous active-high reset and reports idle/drain status.

---
 rtl/xmul_pkg.sv | 13 +
 rtl/xmul_arb_rr_arb.sv | 36 +++
 rtl/xmul_arb.sv | 141 ++++++++++++++
 tb/tb_xmul_arb.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xmul_pkg.sv
// Shared definitions for the xmul_arb multiplier-sharing block.
package xmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Latency of the external 3-stage multiplier, handshake cycle to product.
    localparam int MUL_LAT_DEF = 3;

endpackage

// File: rtl/xmul_arb_rr_arb.sv
// Parameterised round-robin grant: first set request at or after ptr, modulo N.
module rr_arb #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             en,
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    always_comb begin
        int               idx_full;
        logic [IDX_W-1:0] idx;
        // NOTE: every output gets a default before any conditional write, so no latch is inferred.
        gnt      = '0;
        gnt_idx  = '0;
        gnt_vld  = 1'b0;
        idx_full = 0;
        idx      = '0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                idx_full = (int'(ptr) + i) % N;
                idx      = IDX_W'(idx_full);
                if (!gnt_vld && req[idx]) begin
                    gnt[idx] = 1'b1;
                    gnt_idx  = idx;
                    gnt_vld  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/xmul_arb.sv
// Round-robin sequencer sharing one pipelined signed multiplier among N_REQ
// requesters; tags ride alongside the multiplier latency to steer products back.
module xmul_arb
    import xmul_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int TAG_W   = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_op_a,
    input  logic [N_REQ*DATA_W-1:0] req_op_b,
    output logic                  mul_rst,
    output logic [DATA_W-1:0]     mul_op_a,
    output logic [DATA_W-1:0]     mul_op_b,
    input  logic [2*DATA_W-1:0]   mul_product,
    output logic [N_REQ-1:0]      res_valid,
    output logic [2*DATA_W-1:0]   res_data,
    output logic                  idle
);

    logic [1:0]         rst_sync;
    logic [TAG_W-1:0]   ptr;
    logic [N_REQ-1:0]   gnt;
    logic [TAG_W-1:0]   gnt_idx;
    logic               hs;
    logic               eligible;
    logic               busy_next;
    logic [MUL_LAT-1:0] vld_q;
    logic [TAG_W-1:0]   tag_q [MUL_LAT];
    state_e             state_q;
    state_e             state_d;

    // Multiplier reset: asserted with rst, released on the 2nd edge after rst rises.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign mul_rst  = ~rst_sync[1];
    assign eligible = en & ~mul_rst;

    rr_arb #(
        .N     (N_REQ),
        .IDX_W (TAG_W)
    ) u_rr_arb (
        .en      (eligible),
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (hs)
    );

    assign req_ready = gnt;

    // Operands are combinational; the multiplier registers its own inputs.
    always_comb begin
        mul_op_a = '0;
        mul_op_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                mul_op_a = req_op_a[i*DATA_W +: DATA_W];
                mul_op_b = req_op_b[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (hs) begin
            ptr <= (gnt_idx == TAG_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[MUL_LAT-2:0], hs};
        end
    end

    // NOTE: tags are qualified by vld_q, so the tag pipe needs no reset.
    always_ff @(posedge clk) begin
        tag_q[0] <= gnt_idx;
        for (int k = 1; k < MUL_LAT; k++) begin
            tag_q[k] <= tag_q[k-1];
        end
    end

    always_comb begin
        res_valid = '0;
        if (vld_q[MUL_LAT-1]) begin
            res_valid[tag_q[MUL_LAT-1]] = 1'b1;
        end
    end

    assign res_data = mul_product;

    // Work still in flight after this edge; the last stage leaves as it is reported.
    assign busy_next = hs | (|vld_q[MUL_LAT-2:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (en && !mul_rst) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!en) state_d = busy_next ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (en)              state_d = ST_RUN;
                else if (!busy_next) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign idle = (state_q == ST_IDLE);

endmodule

// File: tb/tb_xmul_arb.sv
// Directed bench for xmul_arb with a behavioural 3-stage signed multiplier.
module tb_xmul_arb;

    localparam int DATA_W = 32;
    localparam int N_REQ  = 4;

    logic                    clk;
    logic                    rst;
    logic                    en;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_op_a;
    logic [N_REQ*DATA_W-1:0] req_op_b;
    logic                    mul_rst;
    logic [DATA_W-1:0]       mul_op_a;
    logic [DATA_W-1:0]       mul_op_b;
    logic [2*DATA_W-1:0]     mul_product;
    logic [N_REQ-1:0]        res_valid;
    logic [2*DATA_W-1:0]     res_data;
    logic                    idle;

    int total = 0;
    int bad   = 0;

    xmul_arb #(
        .DATA_W (DATA_W),
        .N_REQ  (N_REQ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op_a    (req_op_a),
        .req_op_b    (req_op_b),
        .mul_rst     (mul_rst),
        .mul_op_a    (mul_op_a),
        .mul_op_b    (mul_op_b),
        .mul_product (mul_product),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .idle        (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: input register, product register, output register.
    logic signed [DATA_W-1:0]   ma;
    logic signed [DATA_W-1:0]   mb;
    logic signed [2*DATA_W-1:0] mp2;
    logic signed [2*DATA_W-1:0] mp3;

    always @(posedge clk) begin
        if (mul_rst) begin
            ma  <= '0;
            mb  <= '0;
            mp2 <= '0;
            mp3 <= '0;
        end else begin
            ma  <= mul_op_a;
            mb  <= mul_op_b;
            mp2 <= ma * mb;
            mp3 <= mp2;
        end
    end

    assign mul_product = mp3;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        req_op_a[i*DATA_W +: DATA_W] = a;
        req_op_b[i*DATA_W +: DATA_W] = b;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        req_op_a  = '0;
        req_op_b  = '0;

        // Reset held for three cycles
        repeat (3) begin
            tick(); #1;
            check("rst_mul_rst", 64'(mul_rst), 64'd1);
            check("rst_ready",   64'(req_ready), 64'd0);
            check("rst_idle",    64'(idle), 64'd1);
            check("rst_res",     64'(res_valid), 64'd0);
        end

        tick(); rst = 1'b1;

        // Multiplier still in reset: request is blocked
        tick();
        en = 1'b1; req_valid = 4'b0001; set_op(0, 32'd7, -32'sd3);
        #1;
        check("rel_mul_rst1", 64'(mul_rst), 64'd1);
        check("rel_blocked",  64'(req_ready), 64'd0);
        check("rel_idle1",    64'(idle), 64'd1);

        // Reset released on the 2nd edge: single request handshakes
        tick(); #1;
        check("rel_mul_rst0", 64'(mul_rst), 64'd0);
        check("single_idle",  64'(idle), 64'd1);
        check("single_ready", 64'(req_ready), 64'b0001);
        check("single_op_a",  64'(mul_op_a), 64'd7);
        check("single_op_b",  64'(mul_op_b), 64'hFFFF_FFFD);

        tick(); req_valid = '0; #1;
        check("run_idle",     64'(idle), 64'd0);
        check("single_res_t1", 64'(res_valid), 64'd0);
        check("op_a_zero",    64'(mul_op_a), 64'd0);

        tick(); #1;
        check("single_res_t2", 64'(res_valid), 64'd0);

        tick(); #1;
        check("single_res_v", 64'(res_valid), 64'b0001);
        check("single_res_d", res_data, -64'sd21);
        // ptr=1, only req3 valid
        req_valid = 4'b1000; set_op(3, 32'd5, 32'd6); #1;
        check("skip_ready3", 64'(req_ready), 64'b1000);

        // All requesters valid, ptr wrapped to 0
        tick();
        req_valid = 4'b1111;
        for (int i = 0; i < N_REQ; i++) set_op(i, DATA_W'(i + 1), 32'h0001_0000);
        #1;
        check("fair_g0", 64'(req_ready), 64'b0001);

        tick(); #1;
        check("fair_g1", 64'(req_ready), 64'b0010);

        tick(); #1;
        check("fair_g2",   64'(req_ready), 64'b0100);
        check("r3_valid",  64'(res_valid), 64'b1000);
        check("r3_data",   res_data, 64'd30);

        tick(); #1;
        check("fair_g3",   64'(req_ready), 64'b1000);
        check("fair_r0_v", 64'(res_valid), 64'b0001);
        check("fair_r0_d", res_data, 64'h1_0000);

        tick(); #1;
        check("fair_g0b",  64'(req_ready), 64'b0001);
        check("fair_r1_v", 64'(res_valid), 64'b0010);
        check("fair_r1_d", res_data, 64'h2_0000);

        // Handshake on req2 leaves ptr=3
        tick();
        req_valid = 4'b0100; set_op(2, -32'sd2, 32'd4); #1;
        check("ptr3_ready", 64'(req_ready), 64'b0100);
        check("fair_r2_v",  64'(res_valid), 64'b0100);
        check("fair_r2_d",  res_data, 64'h3_0000);

        // Wrap and skip: ptr=3, only req1 valid
        tick();
        req_valid = 4'b0010; set_op(1, -32'sd5, -32'sd7); #1;
        check("wrap_ready1", 64'(req_ready), 64'b0010);
        check("fair_r3_v",   64'(res_valid), 64'b1000);
        check("fair_r3_d",   res_data, 64'h4_0000);

        // All valid again: grant to req2 shows ptr became 2
        tick();
        req_valid = 4'b1111; #1;
        check("ptr2_ready", 64'(req_ready), 64'b0100);
        check("fair_r0b_v", 64'(res_valid), 64'b0001);
        check("fair_r0b_d", res_data, 64'h1_0000);

        tick();
        req_valid = '0; #1;
        check("none_ready", 64'(req_ready), 64'd0);
        check("neg_r_v",    64'(res_valid), 64'b0100);
        check("neg_r_d",    res_data, -64'sd8);

        tick(); #1;
        check("wrap_r_v", 64'(res_valid), 64'b0010);
        check("wrap_r_d", res_data, 64'd35);

        tick(); #1;
        check("ptr2_r_v", 64'(res_valid), 64'b0100);
        check("ptr2_r_d", res_data, -64'sd8);

        // Drain: two handshakes on req0, then en drops with req0 still valid
        tick();
        req_valid = 4'b0001; set_op(0, 32'd9, -32'sd9); #1;
        check("drain_hs1", 64'(req_ready), 64'b0001);

        tick();
        set_op(0, -32'sd100000, 32'd100000); #1;
        check("drain_hs2", 64'(req_ready), 64'b0001);

        tick();
        en = 1'b0; #1;
        check("en_low_no_grant", 64'(req_ready), 64'd0);
        check("en_low_op_a",     64'(mul_op_a), 64'd0);
        check("en_low_idle",     64'(idle), 64'd0);

        tick(); #1;
        check("drain_idle1", 64'(idle), 64'd0);
        check("drain_ready", 64'(req_ready), 64'd0);
        check("drain_r1_v",  64'(res_valid), 64'b0001);
        check("drain_r1_d",  res_data, -64'sd81);

        tick(); #1;
        check("drain_idle2", 64'(idle), 64'd0);
        check("drain_r2_v",  64'(res_valid), 64'b0001);
        check("drain_r2_d",  res_data, 64'hFFFF_FFFD_ABF4_1C00);

        tick(); #1;
        check("drain_done_idle", 64'(idle), 64'd1);
        check("drain_done_res",  64'(res_valid), 64'd0);

        // Back-to-back req0: result and handshake coincide
        en = 1'b1; set_op(0, 32'd11, -32'sd2); #1;
        check("b2b_hs0", 64'(req_ready), 64'b0001);
        tick(); #1;
        check("b2b_hs1", 64'(req_ready), 64'b0001);
        tick(); #1;
        check("b2b_hs2", 64'(req_ready), 64'b0001);
        tick(); #1;
        check("coin_ready", 64'(req_ready), 64'b0001);
        check("coin_res_v", 64'(res_valid), 64'b0001);
        check("coin_res_d", res_data, -64'sd22);
        tick();
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("b2b_res_v", 64'(res_valid), 64'b0001);
            check("b2b_res_d", res_data, -64'sd22);
            tick();
        end

        // Reset one cycle after a handshake discards the in-flight result
        req_valid = 4'b0010; set_op(1, 32'd13, 32'd13); #1;
        check("mid_hs", 64'(req_ready), 64'b0010);

        tick();
        req_valid = '0; rst = 1'b0; #1;
        check("mid_res0",    64'(res_valid), 64'd0);
        check("mid_mul_rst", 64'(mul_rst), 64'd1);
        check("mid_idle",    64'(idle), 64'd1);

        tick();
        rst = 1'b1; #1;
        check("mid_res1",     64'(res_valid), 64'd0);
        check("mid_mul_rst1", 64'(mul_rst), 64'd1);

        tick(); #1;
        check("mid_res2",     64'(res_valid), 64'd0);
        check("mid_mul_rst2", 64'(mul_rst), 64'd1);

        tick(); #1;
        check("mid_res3",     64'(res_valid), 64'd0);
        check("mid_mul_rst3", 64'(mul_rst), 64'd0);

        tick(); #1;
        check("mid_res4",  64'(res_valid), 64'd0);
        check("mid_run",   64'(idle), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
